// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns and anode position codes, all active-low
package seg7_pkg;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b0000011;
  localparam logic [6:0] SEG_C    = 7'b1000110;
  localparam logic [6:0] SEG_D    = 7'b0100001;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_F    = 7'b0001110;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_POS3 = 4'b0111;
  localparam logic [3:0] AN_POS2 = 4'b1011;
  localparam logic [3:0] AN_POS1 = 4'b1101;
  localparam logic [3:0] AN_POS0 = 4'b1110;
  localparam logic [3:0] AN_OFF  = 4'b1111;
endpackage

// File: rtl/hex7seg_decoder.sv
// rtl/hex7seg_decoder.sv - byte to segment pattern; values above 0x0F show a dash
module hex7seg_decoder
  import seg7_pkg::*;
(
  input  logic [7:0] value,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    if (value[7:4] == 4'd0) begin
      case (value[3:0])
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        default: seg = SEG_F;
      endcase
    end
  end
endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit multiplexed display driver with per-frame
// input latching and warning blink on the left digit pair
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic [7:0] digit1,
  input  logic [7:0] digit0,
  input  logic [7:0] count1,
  input  logic [7:0] count0,
  input  logic       warning,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [RW-1:0] rcnt;
  logic          tick;
  logic          tick_d;
  logic [1:0]    idx;
  logic [BW-1:0] bcnt;
  logic          blink_ph;
  logic [7:0]    sh_d1, sh_d0, sh_c1, sh_c0;
  logic          sh_warn;

  logic [7:0]    cur_val;
  logic [3:0]    pos_an;
  logic [6:0]    dec_seg;
  logic          blank;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign tick = (rcnt == RW'(REFRESH_DIV - 1));

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      rcnt     <= '0;
      tick_d   <= 1'b0;
      idx      <= 2'd0;
      bcnt     <= '0;
      blink_ph <= 1'b0;
      sh_d1    <= 8'd0;
      sh_d0    <= 8'd0;
      sh_c1    <= 8'd0;
      sh_c0    <= 8'd0;
      sh_warn  <= 1'b0;
      an       <= AN_OFF;
      seg      <= SEG_OFF;
      dp       <= 1'b1;
    end else begin
      rcnt   <= tick ? '0 : rcnt + 1'b1;
      tick_d <= tick;
      if (tick) begin
        if (idx == 2'd0) begin
          // Frame boundary: snapshot inputs so a frame never mixes old and new values
          idx     <= 2'd3;
          sh_d1   <= digit1;
          sh_d0   <= digit0;
          sh_c1   <= count1;
          sh_c0   <= count0;
          sh_warn <= warning;
          if (bcnt == BW'(BLINK_FRAMES - 1)) begin
            bcnt     <= '0;
            blink_ph <= ~blink_ph;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end else begin
          idx <= idx - 2'd1;
        end
      end
      if (tick_d) begin
        an  <= an_next;
        seg <= seg_next;
        dp  <= dp_next;
      end
    end
  end

  always_comb begin
    cur_val = sh_c0;
    pos_an  = AN_POS0;
    case (idx)
      2'd3: begin cur_val = sh_d1; pos_an = AN_POS3; end
      2'd2: begin cur_val = sh_d0; pos_an = AN_POS2; end
      2'd1: begin cur_val = sh_c1; pos_an = AN_POS1; end
      default: begin cur_val = sh_c0; pos_an = AN_POS0; end
    endcase
  end

  hex7seg_decoder u_dec (
    .value (cur_val),
    .seg   (dec_seg)
  );

  // Blanking only hits positions 3 and 2 (idx[1] set); dp on position 3 survives it
  always_comb begin
    blank    = sh_warn & blink_ph & idx[1];
    an_next  = blank ? AN_OFF : pos_an;
    seg_next = blank ? SEG_OFF : dec_seg;
    dp_next  = ~(sh_warn & (idx == 2'd3));
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - randomized bench against a frame/slot arithmetic model
module tb_seven_seg_scanner;
  localparam int RD = 4;
  localparam int BF = 2;

  logic       CLK = 1'b0;
  logic       clear;
  logic [7:0] digit1, digit0, count1, count0;
  logic       warning;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int passed = 0;
  int total  = 0;

  seven_seg_scanner #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .CLK(CLK), .clear(clear), .digit1(digit1), .digit0(digit0),
    .count1(count1), .count0(count0), .warning(warning),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       w;
    logic [7:0] p3, p2, p1, p0;
  } frame_t;

  frame_t     frames[$];
  int         n_edges = 0;
  logic       cmp_en = 1'b0;
  logic [6:0] hex_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got an/seg/dp=%b_%b_%b required %b_%b_%b at %0t",
                  name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0], $time);
  endtask

  // Edges counted since clear fell; the RD-th edge and every 4*RD after it latch a frame
  always @(posedge CLK or posedge clear) begin
    if (clear) begin
      n_edges = 0;
      frames.delete();
    end else begin
      n_edges = n_edges + 1;
      if (n_edges >= RD && (n_edges - RD) % (4 * RD) == 0)
        frames.push_back({warning, digit1, digit0, count1, count0});
    end
  end

  function automatic logic [11:0] model_out(input int n);
    int k, s, f, pos;
    logic ph;
    logic [7:0] v;
    logic [6:0] sg;
    frame_t fr;
    if (n < RD + 1 || frames.size() == 0) return {4'b1111, 7'b1111111, 1'b1};
    k   = n - RD - 1;
    s   = k / RD;
    f   = s / 4;
    pos = 3 - (s % 4);
    if (f >= frames.size()) return 12'hxxx;
    fr  = frames[f];
    ph  = (((f + 1) / BF) % 2) == 1;
    case (pos)
      3: v = fr.p3;
      2: v = fr.p2;
      1: v = fr.p1;
      default: v = fr.p0;
    endcase
    sg = (v < 8'd16) ? hex_tbl[v[3:0]] : 7'b0111111;
    if (fr.w && ph && pos >= 2)
      return {4'b1111, 7'b1111111, (pos == 3) ? 1'b0 : 1'b1};
    return {~(4'b0001 << pos), sg, (fr.w && pos == 3) ? 1'b0 : 1'b1};
  endfunction

  always @(negedge CLK) begin
    if (cmp_en) chk("scan_model", {an, seg, dp}, model_out(n_edges));
  end

  function automatic logic [7:0] rand_val();
    return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
  endfunction

  initial begin
    bit cleared_mid = 0;
    clear = 1'b0; warning = 1'b0;
    digit1 = 8'd3; digit0 = 8'd2; count1 = 8'd0; count0 = 8'd9;
    #2 clear = 1'b1;
    #1 chk("reset_async", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    cmp_en = 1'b1;
    @(negedge CLK) clear = 1'b0;
    repeat (4) @(posedge CLK);
    #2 chk("first_tick_no_change", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    @(posedge CLK);
    #2 chk("pos3_digit1_3", {an, seg, dp}, {4'b0111, 7'b0110000, 1'b1});
    repeat (4) @(posedge CLK);
    #2 chk("pos2_digit0_2", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b1});
    repeat (4) @(posedge CLK);
    #2 chk("pos1_count1_0", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
    repeat (4) @(posedge CLK);
    #2 chk("pos0_count0_9", {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});

    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 7) == 0) digit1 = rand_val();
      if ($urandom_range(0, 7) == 0) digit0 = rand_val();
      if ($urandom_range(0, 7) == 0) count1 = rand_val();
      if ($urandom_range(0, 7) == 0) count0 = rand_val();
      if ($urandom_range(0, 39) == 0) warning = ~warning;
      if (i >= 700 && !cleared_mid && an == 4'b1101) begin
        cleared_mid = 1;
        #2 clear = 1'b1;
        #1 chk("clear_mid_slot", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        @(negedge CLK) clear = 1'b0;
      end
    end
    if (!cleared_mid) chk("clear_mid_slot_reached", 12'h000, 12'hfff);
    @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
